// File: rtl/conv_stream.sv
// rtl/conv_stream.sv - two-stream 1-D linear/circular convolution engine with serial result burst
module conv_stream #(
  parameter int DATA_W = 3,
  parameter int LEN    = 4,
  parameter int OUT_W  = 2 * DATA_W + $clog2(LEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data1,
  input  logic [DATA_W-1:0] in_data2,
  input  logic              mode,
  output logic              out_valid,
  output logic [OUT_W-1:0]  out_data,
  output logic              busy
);

  localparam int IW = (LEN > 1) ? $clog2(LEN) : 1;
  localparam int KW = $clog2(2 * LEN);
  localparam logic [KW-1:0] N_LIN  = KW'(2 * LEN - 1);
  localparam logic [KW-1:0] N_CIRC = KW'(LEN);
  localparam logic [IW-1:0] LAST_IDX = IW'(LEN - 1);

  typedef enum logic [1:0] {IDLE, LOAD, CALC, OUT} state_t;

  state_t            state_q;
  logic [DATA_W-1:0] a_q [LEN];
  logic [DATA_W-1:0] b_q [LEN];
  logic [IW-1:0]     idx_q;
  logic [KW-1:0]     k_q;
  logic              mode_q;
  logic              out_valid_q;
  logic [OUT_W-1:0]  out_data_q;
  logic              busy_q;
  logic [OUT_W-1:0]  conv_d;
  logic [KW-1:0]     n_out;

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;
  assign n_out     = mode_q ? N_CIRC : N_LIN;

  // Result c[k_q]: sum every product a[i]*b[j] whose index pair lands on output k_q
  always_comb begin
    logic [2*DATA_W-1:0] prod;
    logic                hit;
    prod   = '0;
    hit    = 1'b0;
    conv_d = '0;
    for (int i = 0; i < LEN; i++) begin
      for (int j = 0; j < LEN; j++) begin
        prod = a_q[i] * b_q[j];
        hit  = mode_q ? (((i + j) % LEN) == int'(k_q)) : ((i + j) == int'(k_q));
        if (hit) begin
          conv_d = conv_d + OUT_W'(prod);
        end
      end
    end
  end

  // Frame sequencer: capture samples, then stream one registered result per cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      k_q         <= '0;
      mode_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      for (int i = 0; i < LEN; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          out_valid_q <= 1'b0;
          out_data_q  <= '0;
          k_q         <= '0;
          if (in_valid) begin
            a_q[0]  <= in_data1;
            b_q[0]  <= in_data2;
            mode_q  <= mode;
            idx_q   <= IW'(1);
            busy_q  <= 1'b1;
            state_q <= (LEN == 1) ? CALC : LOAD;
          end else begin
            busy_q <= 1'b0;
          end
        end
        LOAD: begin
          if (in_valid) begin
            a_q[idx_q] <= in_data1;
            b_q[idx_q] <= in_data2;
            idx_q      <= idx_q + IW'(1);
            if (idx_q == LAST_IDX) begin
              state_q <= CALC;
            end
          end else begin
            // early end of frame: remaining samples stay zero
            state_q <= CALC;
          end
        end
        CALC: begin
          out_data_q  <= conv_d;
          out_valid_q <= 1'b1;
          k_q         <= k_q + KW'(1);
          state_q     <= OUT;
        end
        OUT: begin
          if (k_q == n_out) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
            idx_q       <= '0;
            k_q         <= '0;
            state_q     <= IDLE;
            for (int i = 0; i < LEN; i++) begin
              a_q[i] <= '0;
              b_q[i] <= '0;
            end
          end else begin
            out_data_q <= conv_d;
            k_q        <= k_q + KW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
